// File: rtl/tile_blitter.sv
// Copies one TILE_W x TILE_H tile of RGB pixels from a synchronous sprite ROM
// to the VGA pixel-write port, with colour-key transparency and horizontal flip.
module tile_blitter #(
    parameter int                TILE_W          = 8,
    parameter int                TILE_H          = 8,
    parameter int                COORD_W         = 8,
    parameter int                ADDR_W          = 12,
    parameter int                CH_W            = 8,
    parameter int                ROM_LATENCY     = 1,
    parameter bit                TRANSPARENT_EN  = 1'b1,
    parameter logic [3*CH_W-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   tile_base,
    input  logic [COORD_W-1:0]  x_origin,
    input  logic [COORD_W-1:0]  y_origin,
    input  logic                flip_x,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [CH_W-1:0]     rom_data,
    output logic                vga_draw_enable,
    input  logic                vga_ready,
    output logic [COORD_W-1:0]  vga_x,
    output logic [COORD_W-1:0]  vga_y,
    output logic [3*CH_W-1:0]   vga_rgb,
    output logic                busy,
    output logic                done
);

    localparam int PX_W = $clog2(TILE_W);
    localparam int PY_W = $clog2(TILE_H);

    localparam logic [PX_W-1:0]    PX_LAST  = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0]    PY_LAST  = PY_W'(TILE_H - 1);
    localparam logic [1:0]         LAT_LAST = 2'(ROM_LATENCY);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(TILE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_R,
        S_FETCH_G,
        S_FETCH_B,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PX_W-1:0]    px_q, px_d;
    logic [PY_W-1:0]    py_q, py_d;
    logic [1:0]         lat_q, lat_d;
    logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic [COORD_W-1:0] x_org_q, x_org_d;
    logic [COORD_W-1:0] y_org_q, y_org_d;
    logic               flip_q, flip_d;
    logic [CH_W-1:0]    r_q, r_d;
    logic [CH_W-1:0]    g_q, g_d;
    logic [CH_W-1:0]    b_q, b_d;

    logic [3*CH_W-1:0]  pixel;
    logic               is_key;
    logic [COORD_W-1:0] col_off;
    logic               fetch_last;

    assign pixel      = {r_q, g_q, b_q};
    assign is_key     = TRANSPARENT_EN && (pixel == TRANSPARENT_KEY);
    assign col_off    = flip_q ? (X_LAST - COORD_W'(px_q)) : COORD_W'(px_q);
    assign fetch_last = (lat_q == LAT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            px_q       <= '0;
            py_q       <= '0;
            lat_q      <= '0;
            pix_addr_q <= '0;
            x_org_q    <= '0;
            y_org_q    <= '0;
            flip_q     <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            lat_q      <= lat_d;
            pix_addr_q <= pix_addr_d;
            x_org_q    <= x_org_d;
            y_org_q    <= y_org_d;
            flip_q     <= flip_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        px_d            = px_q;
        py_d            = py_q;
        lat_d           = lat_q;
        pix_addr_d      = pix_addr_q;
        x_org_d         = x_org_q;
        y_org_d         = y_org_q;
        flip_d          = flip_q;
        r_d             = r_q;
        g_d             = g_q;
        b_d             = b_q;
        rom_addr        = '0;
        vga_draw_enable = 1'b0;
        vga_x           = '0;
        vga_y           = '0;
        vga_rgb         = '0;
        busy            = (state_q != S_IDLE) && (state_q != S_DONE);
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pix_addr_d = tile_base;
                    x_org_d    = x_origin;
                    y_org_d    = y_origin;
                    flip_d     = flip_x;
                    px_d       = '0;
                    py_d       = '0;
                    lat_d      = '0;
                    state_d    = S_FETCH_R;
                end
            end

            S_FETCH_R: begin
                rom_addr = pix_addr_q;
                lat_d    = fetch_last ? 2'd0 : lat_q + 2'd1;
                if (fetch_last) begin
                    r_d     = rom_data;
                    state_d = S_FETCH_G;
                end
            end

            S_FETCH_G: begin
                rom_addr = pix_addr_q + ADDR_W'(1);
                lat_d    = fetch_last ? 2'd0 : lat_q + 2'd1;
                if (fetch_last) begin
                    g_d     = rom_data;
                    state_d = S_FETCH_B;
                end
            end

            S_FETCH_B: begin
                rom_addr = pix_addr_q + ADDR_W'(2);
                lat_d    = fetch_last ? 2'd0 : lat_q + 2'd1;
                if (fetch_last) begin
                    b_d     = rom_data;
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                // Colour-keyed pixels skip the handshake entirely.
                if (is_key) begin
                    state_d = S_NEXT;
                end else begin
                    vga_draw_enable = 1'b1;
                    vga_x           = x_org_q + col_off;
                    vga_y           = y_org_q + COORD_W'(py_q);
                    vga_rgb         = pixel;
                    if (vga_ready) begin
                        state_d = S_NEXT;
                    end
                end
            end

            S_NEXT: begin
                // Raster order: the linear pixel index always advances by one.
                pix_addr_d = pix_addr_q + ADDR_W'(3);
                state_d    = S_FETCH_R;
                if (px_q < PX_LAST) begin
                    px_d = px_q + PX_W'(1);
                end else begin
                    px_d = '0;
                    if (py_q < PY_LAST) begin
                        py_d = py_q + PY_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
